// File: rtl/branch_predictor.sv
// Fetch-side direction/target predictor: direct-mapped 2-bit counter table trained from
// execute-stage outcomes, with a registered one-cycle flush/redirect and saturating stats.
module branch_predictor #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic            flush,
   output logic [XLEN-1:0] redirect_pc,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispred
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic [ENTRIES-1:0] valid_vec;
   logic [TAG_W-1:0]   tag_arr    [ENTRIES];
   logic [XLEN-1:0]    target_arr [ENTRIES];
   logic [1:0]         ctr_arr    [ENTRIES];

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0] if_tag, ex_tag;
   logic             if_hit, ex_hit;
   logic             train, cleanup, mp;
   logic [XLEN-1:0]  correct_pc;

   logic             flush_reg;
   logic [XLEN-1:0]  redirect_reg;
   logic [31:0]      branches_reg, mispred_reg;

   assign if_idx = if_pc[IDX_W+1:2];
   assign if_tag = if_pc[XLEN-1:IDX_W+2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

   // Lookup reads the registered table directly, so a same-cycle update is not visible yet.
   assign if_hit      = valid_vec[if_idx] && (tag_arr[if_idx] == if_tag);
   assign pred_taken  = if_hit && ctr_arr[if_idx][1];
   assign pred_target = pred_taken ? target_arr[if_idx] : if_pc + XLEN'(4);

   assign ex_hit  = valid_vec[ex_idx] && (tag_arr[ex_idx] == ex_tag);
   assign train   = ex_valid && ex_is_branch;
   assign cleanup = ex_valid && !ex_is_branch && ex_pred_taken;

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
         logic             v_reg;
         logic [TAG_W-1:0] tag_reg;
         logic [XLEN-1:0]  target_reg;
         logic [1:0]       ctr_reg;
         logic             sel;

         assign sel = (ex_idx == IDX_W'(gi));

         always_ff @(posedge clk) begin
            if (rst) begin
               v_reg      <= 1'b0;
               tag_reg    <= '0;
               target_reg <= '0;
               ctr_reg    <= 2'b01;
            end else if (sel && train) begin
               if (ex_hit) begin
                  if (ex_taken) begin
                     if (ctr_reg != 2'b11) ctr_reg <= ctr_reg + 2'b01;
                     target_reg <= ex_target;
                  end else if (ctr_reg != 2'b00) begin
                     ctr_reg <= ctr_reg - 2'b01;
                  end
               end else if (ex_taken) begin
                  v_reg      <= 1'b1;
                  tag_reg    <= ex_tag;
                  target_reg <= ex_target;
                  ctr_reg    <= 2'b10;
               end
            end else if (sel && cleanup) begin
               // A non-branch predicted taken means this entry aliases onto it; drop it.
               v_reg <= 1'b0;
            end
         end

         assign valid_vec[gi]  = v_reg;
         assign tag_arr[gi]    = tag_reg;
         assign target_arr[gi] = target_reg;
         assign ctr_arr[gi]    = ctr_reg;
      end
   endgenerate

   always_comb begin
      mp = 1'b0;
      if (ex_valid) begin
         if (ex_is_branch)
            mp = (ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target));
         else
            mp = ex_pred_taken;
      end
      correct_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + XLEN'(4);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flush_reg    <= 1'b0;
         redirect_reg <= '0;
         branches_reg <= '0;
         mispred_reg  <= '0;
      end else begin
         flush_reg <= mp;
         if (mp) redirect_reg <= correct_pc;
         if (train && (branches_reg != 32'hFFFF_FFFF)) branches_reg <= branches_reg + 32'd1;
         if (mp && (mispred_reg != 32'hFFFF_FFFF)) mispred_reg <= mispred_reg + 32'd1;
      end
   end

   assign flush         = flush_reg;
   assign redirect_pc   = redirect_reg;
   assign stat_branches = branches_reg;
   assign stat_mispred  = mispred_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized check of branch_predictor against a table-of-records model.
module tb_branch_predictor;
   localparam int XLEN    = 32;
   localparam int ENTRIES = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [XLEN-1:0] if_pc = '0;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            ex_valid = 1'b0, ex_is_branch = 1'b0, ex_taken = 1'b0, ex_pred_taken = 1'b0;
   logic [XLEN-1:0] ex_pc = '0, ex_target = '0, ex_pred_target = '0;
   logic            flush;
   logic [XLEN-1:0] redirect_pc;
   logic [31:0]     stat_branches, stat_mispred;

   branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_taken(ex_taken),
      .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .flush(flush), .redirect_pc(redirect_pc), .stat_branches(stat_branches),
      .stat_mispred(stat_mispred)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        v;
      bit [31:0] tag;
      bit [31:0] tgt;
      int        ctr;
   } ent_t;

   ent_t      tbl [ENTRIES];
   bit        m_flush;
   bit [31:0] m_redir, m_br, m_mp;
   int        vectors = 0;
   int        miscompares = 0;
   int        txn = 0;

   function automatic int midx(bit [31:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic bit [31:0] mtag(bit [31:0] pc);
      return pc / (4 * ENTRIES);
   endfunction

   function automatic bit mhit(bit [31:0] pc);
      return tbl[midx(pc)].v && (tbl[midx(pc)].tag == mtag(pc));
   endfunction

   task automatic mlookup(input bit [31:0] pc, output bit tk, output bit [31:0] tg);
      if (mhit(pc) && tbl[midx(pc)].ctr >= 2) begin
         tk = 1'b1;
         tg = tbl[midx(pc)].tgt;
      end else begin
         tk = 1'b0;
         tg = pc + 32'd4;
      end
   endtask

   task automatic mreset();
      for (int i = 0; i < ENTRIES; i++) tbl[i] = '{v: 1'b0, tag: 32'd0, tgt: 32'd0, ctr: 1};
      m_flush = 1'b0;
      m_redir = 32'd0;
      m_br    = 32'd0;
      m_mp    = 32'd0;
   endtask

   // Applies one rising edge worth of behaviour using the inputs as held across the edge.
   task automatic mclock();
      bit        is_mp;
      bit [31:0] cpc;
      int        i;
      if (rst) begin
         mreset();
         return;
      end
      m_flush = 1'b0;
      if (!ex_valid) return;
      if (ex_is_branch)
         is_mp = (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target);
      else
         is_mp = ex_pred_taken;
      cpc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
      m_flush = is_mp;
      if (is_mp) m_redir = cpc;
      if (is_mp && m_mp != 32'hFFFF_FFFF) m_mp++;
      i = midx(ex_pc);
      if (ex_is_branch) begin
         if (m_br != 32'hFFFF_FFFF) m_br++;
         if (mhit(ex_pc)) begin
            if (ex_taken) begin
               tbl[i].ctr = (tbl[i].ctr < 3) ? tbl[i].ctr + 1 : 3;
               tbl[i].tgt = ex_target;
            end else begin
               tbl[i].ctr = (tbl[i].ctr > 0) ? tbl[i].ctr - 1 : 0;
            end
         end else if (ex_taken) begin
            tbl[i] = '{v: 1'b1, tag: mtag(ex_pc), tgt: ex_target, ctr: 2};
         end
      end else if (ex_pred_taken) begin
         tbl[i].v = 1'b0;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_pred(input string nm);
      bit        tk;
      bit [31:0] tg;
      mlookup(if_pc, tk, tg);
      chk({nm, "_pred_taken"}, {31'd0, pred_taken}, {31'd0, tk});
      chk({nm, "_pred_target"}, pred_target, tg);
   endtask

   task automatic drive(input bit v, input bit br, input bit [31:0] pc, input bit tk,
                        input bit [31:0] tgt, input bit ptk, input bit [31:0] ptgt,
                        input bit [31:0] fpc);
      ex_valid = v; ex_is_branch = br; ex_pc = pc; ex_taken = tk; ex_target = tgt;
      ex_pred_taken = ptk; ex_pred_target = ptgt; if_pc = fpc;
   endtask

   // One transaction: check lookup against pre-edge state, clock, check everything after.
   task automatic cycle();
      #1 chk_pred("pre");
      @(posedge clk);
      mclock();
      @(negedge clk);
      txn++;
      $display("txn %0d rst=%0b v=%0b br=%0b pc=%h tk=%0b tgt=%h ptk=%0b if=%h -> flush=%0b redir=%h",
               txn, rst, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred_taken,
               if_pc, flush, redirect_pc);
      chk_pred("post");
      chk("flush", {31'd0, flush}, {31'd0, m_flush});
      chk("redirect_pc", redirect_pc, m_redir);
      chk("stat_branches", stat_branches, m_br);
      chk("stat_mispred", stat_mispred, m_mp);
   endtask

   task automatic lit_pred(input string nm, input bit [31:0] pc, input bit tk, input bit [31:0] tg);
      if_pc = pc;
      #1;
      chk({nm, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
      chk({nm, "_target"}, pred_target, tg);
   endtask

   initial begin
      bit        tk;
      bit [31:0] tg, pc, tgt;
      bit [31:0] pcs [8];
      bit [31:0] tgts [4];
      pcs  = '{32'h100, 32'h200, 32'h104, 32'h300, 32'h108, 32'h1100, 32'h204, 32'h0};
      tgts = '{32'h40, 32'h80, 32'h1000, 32'h0};

      // 1. reset
      drive(0, 0, 0, 0, 0, 0, 0, 32'h100);
      rst = 1'b1;
      @(posedge clk);
      mreset();
      @(negedge clk);
      rst = 1'b0;
      lit_pred("t1", 32'h100, 1'b0, 32'h104);
      chk("t1_flush", {31'd0, flush}, 32'd0);
      chk("t1_stats", stat_branches | stat_mispred, 32'd0);

      // 2. first taken resolution allocates and mispredicts
      drive(1, 1, 32'h100, 1, 32'h80, 0, 32'h104, 32'h100);
      cycle();
      chk("t2_flush", {31'd0, flush}, 32'd1);
      chk("t2_redirect", redirect_pc, 32'h80);
      chk("t2_mispred", stat_mispred, 32'd1);
      lit_pred("t2", 32'h100, 1'b1, 32'h80);

      // 3. not-taken twice, then once more, then taken: counter must sit at 00 not wrap
      drive(1, 1, 32'h100, 0, 32'h80, 1, 32'h80, 32'h100);
      cycle();
      chk("t3_flush", {31'd0, flush}, 32'd1);
      chk("t3_redirect", redirect_pc, 32'h104);
      lit_pred("t3a", 32'h100, 1'b0, 32'h104);
      drive(1, 1, 32'h100, 0, 32'h80, 0, 32'h104, 32'h100);
      cycle();
      chk("t3_noflush", {31'd0, flush}, 32'd0);
      cycle();
      drive(1, 1, 32'h100, 1, 32'h80, 0, 32'h104, 32'h100);
      cycle();
      lit_pred("t3_sat", 32'h100, 1'b0, 32'h104);

      // 4. aliasing: 0x200 replaces 0x100 at the same index
      drive(1, 1, 32'h200, 1, 32'h40, 0, 32'h204, 32'h200);
      cycle();
      lit_pred("t4_alias", 32'h100, 1'b0, 32'h104);
      lit_pred("t4_own", 32'h200, 1'b1, 32'h40);

      // 5. non-branch predicted taken: flush and invalidate
      drive(1, 0, 32'h200, 0, 32'h0, 1, 32'h40, 32'h200);
      cycle();
      chk("t5_flush", {31'd0, flush}, 32'd1);
      chk("t5_redirect", redirect_pc, 32'h204);
      lit_pred("t5_inval", 32'h200, 1'b0, 32'h204);

      // 6. same-index lookup and update, then reset mid-flush
      drive(1, 1, 32'h100, 1, 32'h80, 0, 32'h104, 32'h100);
      cycle();
      drive(1, 1, 32'h100, 0, 32'h80, 1, 32'h80, 32'h100);
      lit_pred("t6_old", 32'h100, 1'b1, 32'h80);
      cycle();
      chk("t6_new", {31'd0, pred_taken}, 32'd0);
      chk("t6_flush", {31'd0, flush}, 32'd1);
      rst = 1'b1;
      drive(1, 1, 32'h300, 1, 32'h40, 0, 32'h304, 32'h100);
      cycle();
      rst = 1'b0;
      chk("t6_rst_flush", {31'd0, flush}, 32'd0);
      chk("t6_rst_stats", stat_branches, 32'd0);
      lit_pred("t6_rst_a", 32'h100, 1'b0, 32'h104);
      lit_pred("t6_rst_b", 32'h300, 1'b0, 32'h304);

      // randomized traffic over a small PC pool so hits, aliasing and cleanup all recur
      for (int n = 0; n < 400; n++) begin
         pc  = ($urandom_range(0, 7) == 7) ? ($urandom & 32'hFFFF_FFFC) : pcs[$urandom_range(0, 6)];
         tgt = ($urandom_range(0, 3) == 3) ? ($urandom & 32'hFFFF_FFFC) : tgts[$urandom_range(0, 2)];
         if ($urandom_range(0, 1) == 1) begin
            mlookup(pc, tk, tg);
         end else begin
            tk = 1'($urandom_range(0, 1));
            tg = tk ? tgts[$urandom_range(0, 2)] : pc + 32'd4;
         end
         rst = ($urandom_range(0, 99) == 0);
         drive($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, pc, 1'($urandom_range(0, 1)),
               tgt, tk, tg, pcs[$urandom_range(0, 6)]);
         cycle();
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
